// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants, state encoding and helpers for the Mini-MIPS fetch stage.
package instruction_fetch_unit_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC   = 10'd0;
  localparam logic [DATA_W-1:0] HALT_INSTR = 32'hFC00_0000;
  localparam logic [ADDR_W-1:0] PC_ONE     = 10'd1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Instruction counter stops at all-ones rather than wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Control, instruction-memory read port and IF/ID outputs of the fetch stage.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic              start;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              halted;
  logic [31:0]       fetch_count;

  // Core side: loader/decode/memory drive the fetch unit and observe it.
  modport master (
    output start, stall, redirect_valid, redirect_pc, imem_data,
    input  imem_addr, if_valid, if_instr, if_pc, halted, fetch_count
  );

  // Fetch unit side.
  modport slave (
    input  start, stall, redirect_valid, redirect_pc, imem_data,
    output imem_addr, if_valid, if_instr, if_pc, halted, fetch_count
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// registers the result into the IF/ID register.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for start after reset; redirect/stall ignored
// ST_RUN    | fetching one word per non-stalled cycle; redirect flushes IF/ID
// ST_HALTED | HALT word captured; PC frozen until the next start
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  instruction_fetch_unit_if.slave bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              halted_q, halted_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  // Next-state, PC mux and IF/ID register update for one clock edge.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d       = ST_RUN;
          pc_d          = RESET_PC;
          fetch_count_d = 32'd0;
          if_valid_d    = 1'b0;
        end
      end

      ST_RUN: begin
        // Redirect wins over stall and over a wrong-path HALT word.
        if (bus.redirect_valid) begin
          pc_d       = bus.redirect_pc;
          if_valid_d = 1'b0;
        end else if (!bus.stall) begin
          if_instr_d    = bus.imem_data;
          if_pc_d       = pc_q;
          if_valid_d    = 1'b1;
          fetch_count_d = sat_inc(fetch_count_q);
          if (bus.imem_data == HALT_INSTR) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end

      ST_HALTED: begin
        if (bus.start) begin
          state_d       = ST_RUN;
          pc_d          = RESET_PC;
          halted_d      = 1'b0;
          fetch_count_d = 32'd0;
          if_valid_d    = 1'b0;
        end else if (!bus.stall) begin
          // HALT word stays visible to decode until it is consumed.
          if_valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and IF/ID register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      halted_q      <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fetch_count_q;

endmodule
